// File: rtl/mem_acc_ldst_port.sv
// mem_acc_ldst_port
//   Memory-access-controller endpoint for one PE's LD/ST interface. The LD/ST
//   unit asks for ownership of the PE SRAM. Ownership is granted only while the
//   DMA engine is idle, and a grant already held is never revoked. Once granted,
//   write and read requests are accepted under valid/ready flow control and are
//   issued to the SRAM one cycle later. Read data is returned in request order
//   through a small return FIFO that the LD/ST unit can stall with read_pause.
//
// Ports
//   clk, reset_poweron            sole clock; synchronous active-high reset
//   ldst__memc__request/released  ownership request / release from LD/ST
//   memc__ldst__granted           ownership held (GRANTED or DRAIN)
//   ldst__memc__write_*           write request channel, memc__ldst__write_ready
//   ldst__memc__read_*            read request channel, memc__ldst__read_ready
//   memc__ldst__read_data(_valid) read return channel, stalled by ldst__memc__read_pause
//   dmac__memc__busy              DMA owns the SRAM; blocks a new grant only
//   memc__sram__*                 registered SRAM access port
//   sram__memc__rdata             SRAM read data, MEM_RD_LATENCY cycles after enable

module mem_acc_ldst_port #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_RD_LATENCY = 2,
  parameter int RD_FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  ldst__memc__request,
  output logic                  memc__ldst__granted,
  input  logic                  ldst__memc__released,
  input  logic                  ldst__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__write_address,
  input  logic [DATA_WIDTH-1:0] ldst__memc__write_data,
  output logic                  memc__ldst__write_ready,
  input  logic                  ldst__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__read_address,
  output logic                  memc__ldst__read_ready,
  output logic [DATA_WIDTH-1:0] memc__ldst__read_data,
  output logic                  memc__ldst__read_data_valid,
  input  logic                  ldst__memc__read_pause,
  input  logic                  dmac__memc__busy,
  output logic                  memc__sram__enable,
  output logic                  memc__sram__write,
  output logic [ADDR_WIDTH-1:0] memc__sram__address,
  output logic [DATA_WIDTH-1:0] memc__sram__wdata,
  input  logic [DATA_WIDTH-1:0] sram__memc__rdata
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  granted_reg;

  logic                  sram_enable_reg;
  logic                  sram_write_reg;
  logic [ADDR_WIDTH-1:0] sram_address_reg;
  logic [DATA_WIDTH-1:0] sram_wdata_reg;

  logic [CNT_W-1:0]      outstanding_reg;
  logic [CNT_W-1:0]      outstanding_next;

  logic [MEM_RD_LATENCY-1:0] rd_tag_reg;
  logic [MEM_RD_LATENCY-1:0] rd_tag_next;

  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
  logic [CNT_W-1:0]      fifo_wr_ptr_reg;
  logic [CNT_W-1:0]      fifo_rd_ptr_reg;

  logic wr_accept;
  logic rd_accept;
  logic rd_pop;
  logic fifo_push;
  logic fifo_empty;
  logic sram_rd_issued;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Request-side handshakes
  // ---------------------------------------------------------------------------
  // Reads are capped by the outstanding count (SRAM pipeline + FIFO), so the
  // FIFO always has room for every rdata beat that comes back.
  assign memc__ldst__write_ready = (state_reg == ST_GRANTED);
  assign memc__ldst__read_ready  = (state_reg == ST_GRANTED) &&
                                   !ldst__memc__write_valid &&
                                   (outstanding_reg < DEPTH_CNT);

  assign wr_accept = ldst__memc__write_valid && memc__ldst__write_ready;
  assign rd_accept = ldst__memc__read_valid  && memc__ldst__read_ready;

  assign memc__ldst__granted = granted_reg;

  // ---------------------------------------------------------------------------
  // Ownership FSM
  // ---------------------------------------------------------------------------
  // DRAIN keeps the grant asserted until every accepted read has been handed
  // back, so the LD/ST unit never loses data it already asked for.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_reg   <= ST_IDLE;
      granted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ldst__memc__request && !dmac__memc__busy) begin
            state_reg   <= ST_GRANTED;
            granted_reg <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (ldst__memc__released && !ldst__memc__request) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((outstanding_reg == '0) && fifo_empty) begin
            state_reg   <= ST_IDLE;
            granted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          granted_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM issue register: one access per accepted request, all-zero otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      sram_enable_reg  <= 1'b0;
      sram_write_reg   <= 1'b0;
      sram_address_reg <= '0;
      sram_wdata_reg   <= '0;
    end else if (wr_accept) begin
      sram_enable_reg  <= 1'b1;
      sram_write_reg   <= 1'b1;
      sram_address_reg <= ldst__memc__write_address;
      sram_wdata_reg   <= ldst__memc__write_data;
    end else if (rd_accept) begin
      sram_enable_reg  <= 1'b1;
      sram_write_reg   <= 1'b0;
      sram_address_reg <= ldst__memc__read_address;
      sram_wdata_reg   <= '0;
    end else begin
      sram_enable_reg  <= 1'b0;
      sram_write_reg   <= 1'b0;
      sram_address_reg <= '0;
      sram_wdata_reg   <= '0;
    end
  end

  assign memc__sram__enable  = sram_enable_reg;
  assign memc__sram__write   = sram_write_reg;
  assign memc__sram__address = sram_address_reg;
  assign memc__sram__wdata   = sram_wdata_reg;

  // ---------------------------------------------------------------------------
  // Read tag pipeline: marks the cycle in which SRAM rdata belongs to a read
  // ---------------------------------------------------------------------------
  // Bit k is set in the cycle k+1 after the read appeared on the SRAM port, so
  // the top bit lines up with the cycle in which rdata is valid.
  assign sram_rd_issued = sram_enable_reg && !sram_write_reg;
  assign rd_tag_next[0] = sram_rd_issued;

  generate
    for (gi = 1; gi < MEM_RD_LATENCY; gi++) begin : g_rd_tag
      assign rd_tag_next[gi] = rd_tag_reg[gi-1];
    end
  endgenerate

  // Clearing the tags on reset is what discards rdata from pre-reset reads.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      rd_tag_reg <= '0;
    end else begin
      rd_tag_reg <= rd_tag_next;
    end
  end

  assign fifo_push = rd_tag_reg[MEM_RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Return FIFO
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // The head is shown combinationally; pushes only touch the tail, so the
  // presented beat stays stable while the consumer pauses.
  assign fifo_empty = (fifo_wr_ptr_reg == fifo_rd_ptr_reg);
  assign rd_pop     = !fifo_empty && !ldst__memc__read_pause;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[fifo_wr_ptr_reg[PTR_W-1:0]] <= sram__memc__rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
    end else begin
      if (fifo_push) begin
        fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 1'b1;
      end
      if (rd_pop) begin
        fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
      end
    end
  end

  assign memc__ldst__read_data_valid = !fifo_empty;
  assign memc__ldst__read_data       = fifo_empty ? '0
                                       : fifo_mem[fifo_rd_ptr_reg[PTR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Outstanding reads: accepted but not yet handed back to the LD/ST unit
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_next = outstanding_reg;
    if (rd_accept && !rd_pop) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!rd_accept && rd_pop) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      outstanding_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

endmodule

// File: tb/tb_mem_acc_ldst_port.sv
// tb_mem_acc_ldst_port
//   Self-checking bench for mem_acc_ldst_port. A behavioural SRAM answers the
//   DUT's SRAM port with MEM_RD_LATENCY cycles of read latency and drives
//   random data in cycles that carry no read. Two scoreboards are filled from
//   the bench's own view of accepted requests: one for SRAM issues and one for
//   returned read data (from a reference memory updated by accepted writes).

module tb_mem_acc_ldst_port;

  localparam int AW    = 24;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int SW    = 1 + AW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_poweron = 1'b1;
  logic          ldst__memc__request = 1'b0;
  logic          ldst__memc__released = 1'b0;
  logic          ldst__memc__write_valid = 1'b0;
  logic [AW-1:0] ldst__memc__write_address = '0;
  logic [DW-1:0] ldst__memc__write_data = '0;
  logic          ldst__memc__read_valid = 1'b0;
  logic [AW-1:0] ldst__memc__read_address = '0;
  logic          ldst__memc__read_pause = 1'b0;
  logic          dmac__memc__busy = 1'b0;
  logic [DW-1:0] sram__memc__rdata = '0;

  logic          memc__ldst__granted;
  logic          memc__ldst__write_ready;
  logic          memc__ldst__read_ready;
  logic [DW-1:0] memc__ldst__read_data;
  logic          memc__ldst__read_data_valid;
  logic          memc__sram__enable;
  logic          memc__sram__write;
  logic [AW-1:0] memc__sram__address;
  logic [DW-1:0] memc__sram__wdata;

  mem_acc_ldst_port #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_RD_LATENCY(LAT),
    .RD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .ldst__memc__request        (ldst__memc__request),
    .memc__ldst__granted        (memc__ldst__granted),
    .ldst__memc__released       (ldst__memc__released),
    .ldst__memc__write_valid    (ldst__memc__write_valid),
    .ldst__memc__write_address  (ldst__memc__write_address),
    .ldst__memc__write_data     (ldst__memc__write_data),
    .memc__ldst__write_ready    (memc__ldst__write_ready),
    .ldst__memc__read_valid     (ldst__memc__read_valid),
    .ldst__memc__read_address   (ldst__memc__read_address),
    .memc__ldst__read_ready     (memc__ldst__read_ready),
    .memc__ldst__read_data      (memc__ldst__read_data),
    .memc__ldst__read_data_valid(memc__ldst__read_data_valid),
    .ldst__memc__read_pause     (ldst__memc__read_pause),
    .dmac__memc__busy           (dmac__memc__busy),
    .memc__sram__enable         (memc__sram__enable),
    .memc__sram__write          (memc__sram__write),
    .memc__sram__address        (memc__sram__address),
    .memc__sram__wdata          (memc__sram__wdata),
    .sram__memc__rdata          (sram__memc__rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboards and memories
  logic [DW-1:0] exp_rd_q [$];
  logic [SW-1:0] exp_sram_q [$];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_dly [LAT+1];
  logic          hold_valid = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [SW-1:0] sram_exp;
  logic [DW-1:0] rd_exp;

  // Monitor + SRAM model, evaluated mid-cycle when everything has settled.
  always @(negedge clk) begin
    if (reset_poweron) begin
      exp_rd_q.delete();
      exp_sram_q.delete();
      hold_valid = 1'b0;
    end else begin
      // SRAM port against issued-request scoreboard
      if (memc__sram__enable) begin
        if (exp_sram_q.size() == 0) begin
          check_value("sram_spurious", memc__sram__enable, 1'b0);
        end else begin
          sram_exp = exp_sram_q.pop_front();
          check_value("sram_issue",
                      {memc__sram__write, memc__sram__address, memc__sram__wdata},
                      sram_exp);
        end
      end else begin
        check_value("sram_idle_zero",
                    {memc__sram__write, memc__sram__address, memc__sram__wdata}, '0);
      end

      // Read return channel
      if (memc__ldst__read_data_valid) begin
        if (hold_valid) check_value("rd_hold_data", memc__ldst__read_data, hold_data);
        if (!ldst__memc__read_pause) begin
          hold_valid = 1'b0;
          if (exp_rd_q.size() == 0) begin
            check_value("rd_spurious", memc__ldst__read_data_valid, 1'b0);
          end else begin
            rd_exp = exp_rd_q.pop_front();
            $display("[%0t] RET data=%h", $time, memc__ldst__read_data);
            check_value("rd_data", memc__ldst__read_data, rd_exp);
          end
        end else begin
          hold_valid = 1'b1;
          hold_data  = memc__ldst__read_data;
        end
      end else begin
        if (hold_valid) check_value("rd_hold_valid", memc__ldst__read_data_valid, 1'b1);
        hold_valid = 1'b0;
      end

      // Accepted requests
      if (ldst__memc__write_valid && memc__ldst__write_ready) begin
        ref_mem[ldst__memc__write_address] = ldst__memc__write_data;
        exp_sram_q.push_back({1'b1, ldst__memc__write_address, ldst__memc__write_data});
        $display("[%0t] WR  addr=%h data=%h", $time, ldst__memc__write_address,
                 ldst__memc__write_data);
      end
      if (ldst__memc__read_valid && memc__ldst__read_ready) begin
        exp_sram_q.push_back({1'b0, ldst__memc__read_address, {DW{1'b0}}});
        exp_rd_q.push_back(ref_mem.exists(ldst__memc__read_address) ?
                           ref_mem[ldst__memc__read_address] : '0);
        $display("[%0t] RD  addr=%h", $time, ldst__memc__read_address);
      end
    end

    // Behavioural SRAM: rdata for a read enabled in cycle C appears in C+LAT.
    for (int k = 0; k < LAT; k++) rd_dly[k] = rd_dly[k+1];
    if (memc__sram__enable && !memc__sram__write) begin
      rd_dly[LAT] = sram_mem.exists(memc__sram__address) ?
                    sram_mem[memc__sram__address] : '0;
    end else begin
      rd_dly[LAT] = {$urandom, $urandom};
    end
    if (memc__sram__enable && memc__sram__write) begin
      sram_mem[memc__sram__address] = memc__sram__wdata;
    end
    sram__memc__rdata = rd_dly[0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check_value({pfx, "_granted"}, memc__ldst__granted, 1'b0);
    check_value({pfx, "_wready"}, memc__ldst__write_ready, 1'b0);
    check_value({pfx, "_rready"}, memc__ldst__read_ready, 1'b0);
    check_value({pfx, "_rvalid"}, memc__ldst__read_data_valid, 1'b0);
    check_value({pfx, "_rdata"}, memc__ldst__read_data, '0);
    check_value({pfx, "_sram"}, {memc__sram__enable, memc__sram__write,
                                 memc__sram__address, memc__sram__wdata}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int beats;
    int beats_at5;
    int budget;

    for (int k = 0; k <= LAT; k++) rd_dly[k] = '0;

    // Reset
    step();
    step();
    sample();
    check_all_zero("rst");

    // Grant: request in cycle 0 -> granted in cycle 1
    step();
    reset_poweron = 1'b0;
    ldst__memc__request = 1'b1;
    sample();
    check_value("grant_c0", memc__ldst__granted, 1'b0);
    step();
    sample();
    check_value("grant_c1", memc__ldst__granted, 1'b1);
    check_value("wready_c1", memc__ldst__write_ready, 1'b1);

    // Write 0x10 <- 0xDEAD in cycle 2, issued in cycle 3
    step();
    ldst__memc__write_valid   = 1'b1;
    ldst__memc__write_address = 24'h10;
    ldst__memc__write_data    = 64'hDEAD;
    sample();
    check_value("wr_blocks_rd", memc__ldst__read_ready, 1'b0);
    step();
    ldst__memc__write_valid = 1'b0;
    sample();
    check_value("wr_issue", {memc__sram__enable, memc__sram__write,
                             memc__sram__address, memc__sram__wdata},
                {2'b11, 24'h10, 64'hDEAD});
    step();
    sample();

    // Read 0x10 accepted in cycle 5 -> valid exactly in cycle 9
    step();
    ldst__memc__read_valid   = 1'b1;
    ldst__memc__read_address = 24'h10;
    sample();
    check_value("lat_rd_ready", memc__ldst__read_ready, 1'b1);
    for (int c = 6; c <= 10; c++) begin
      step();
      ldst__memc__read_valid = 1'b0;
      sample();
      check_value($sformatf("lat_valid_c%0d", c), memc__ldst__read_data_valid, (c == 9));
      if (c == 9) check_value("lat_data", memc__ldst__read_data, 64'hDEAD);
    end

    // Flow control: six writes, then six reads under pause
    for (int i = 0; i < 6; i++) begin
      step();
      ldst__memc__write_valid   = 1'b1;
      ldst__memc__write_address = AW'(32'h20 + i);
      ldst__memc__write_data    = {32'hC0DE0000 + 32'(i), $urandom};
    end
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      ldst__memc__write_valid  = 1'b0;
      ldst__memc__read_pause   = 1'b1;
      ldst__memc__read_valid   = 1'b1;
      ldst__memc__read_address = AW'(32'h20 + acc);
      sample();
      if (memc__ldst__read_ready) acc++;
    end
    check_value("fc_acc_limit", acc, 4);
    check_value("fc_ready_low", memc__ldst__read_ready, 1'b0);
    beats = 0;
    beats_at5 = -1;
    budget = 40;
    while ((acc < 6 || beats < 6) && budget > 0) begin
      budget--;
      step();
      ldst__memc__read_pause   = 1'b0;
      ldst__memc__read_valid   = (acc < 6);
      ldst__memc__read_address = AW'(32'h20 + acc);
      sample();
      if (memc__ldst__read_data_valid && !ldst__memc__read_pause) beats++;
      if (ldst__memc__read_valid && memc__ldst__read_ready) begin
        acc++;
        if (acc == 5) beats_at5 = beats;
      end
    end
    check_value("fc_acc_total", acc, 6);
    check_value("fc_beats_total", beats, 6);
    check_value("fc_beat_before_acc5", (beats_at5 >= 1), 1'b1);

    // Arbitration: write and read together -> write first, read next cycle
    step();
    ldst__memc__read_valid    = 1'b1;
    ldst__memc__read_address  = 24'h30;
    ldst__memc__write_valid   = 1'b1;
    ldst__memc__write_address = 24'h30;
    ldst__memc__write_data    = 64'h1234_5678_9ABC_DEF0;
    sample();
    check_value("arb_wr_ready", memc__ldst__write_ready, 1'b1);
    check_value("arb_rd_blocked", memc__ldst__read_ready, 1'b0);
    step();
    ldst__memc__write_valid = 1'b0;
    sample();
    check_value("arb_wr_issued", {memc__sram__enable, memc__sram__write}, 2'b11);
    check_value("arb_rd_next", memc__ldst__read_ready, 1'b1);
    step();
    ldst__memc__read_valid = 1'b0;
    sample();
    check_value("arb_rd_issued", {memc__sram__enable, memc__sram__write,
                                  memc__sram__address}, {2'b10, 24'h30});
    repeat (6) step();
    check_value("sb_rd_empty", exp_rd_q.size(), 0);
    check_value("sb_sram_empty", exp_sram_q.size(), 0);

    // Grant retention rules
    ldst__memc__request = 1'b0;
    sample();
    step();
    sample();
    check_value("keep_grant_noreq", memc__ldst__write_ready, 1'b1);
    step();
    ldst__memc__request  = 1'b1;
    ldst__memc__released = 1'b1;
    sample();
    step();
    ldst__memc__released = 1'b0;
    sample();
    check_value("rel_ignored", memc__ldst__write_ready, 1'b1);
    step();
    dmac__memc__busy = 1'b1;
    sample();
    step();
    sample();
    check_value("busy_no_revoke", memc__ldst__write_ready, 1'b1);

    // Release with nothing outstanding
    step();
    dmac__memc__busy     = 1'b0;
    ldst__memc__request  = 1'b0;
    ldst__memc__released = 1'b1;
    sample();
    check_value("rel_c0_granted", memc__ldst__granted, 1'b1);
    step();
    ldst__memc__released = 1'b0;
    sample();
    check_value("rel_c1_granted", memc__ldst__granted, 1'b1);
    check_value("rel_c1_readys", {memc__ldst__write_ready, memc__ldst__read_ready}, 2'b00);
    step();
    sample();
    check_value("rel_c2_granted", memc__ldst__granted, 1'b0);

    // DMA busy blocks a new grant
    step();
    dmac__memc__busy    = 1'b1;
    ldst__memc__request = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      sample();
      check_value("busy_blocks", memc__ldst__granted, 1'b0);
    end
    step();
    dmac__memc__busy = 1'b0;
    sample();
    check_value("busy_fall_c0", memc__ldst__granted, 1'b0);
    step();
    sample();
    check_value("busy_fall_c1", memc__ldst__granted, 1'b1);

    // Release while two reads are in flight
    for (int i = 0; i < 2; i++) begin
      step();
      ldst__memc__read_valid   = 1'b1;
      ldst__memc__read_address = AW'(32'h22 + i);
      sample();
      check_value("drain_rd_acc", memc__ldst__read_ready, 1'b1);
    end
    step();
    ldst__memc__read_valid = 1'b0;
    ldst__memc__request    = 1'b0;
    ldst__memc__released   = 1'b1;
    sample();
    step();
    ldst__memc__released = 1'b0;
    beats = 0;
    budget = 20;
    while (budget > 0) begin
      budget--;
      sample();
      if (!memc__ldst__granted) break;
      check_value("drain_readys", {memc__ldst__write_ready, memc__ldst__read_ready}, 2'b00);
      if (memc__ldst__read_data_valid && !ldst__memc__read_pause) beats++;
      step();
    end
    check_value("drain_done", memc__ldst__granted, 1'b0);
    check_value("drain_beats", beats, 2);

    // Reset with three reads outstanding
    step();
    ldst__memc__request = 1'b1;
    sample();
    step();
    sample();
    check_value("mid_grant", memc__ldst__granted, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      ldst__memc__read_valid   = 1'b1;
      ldst__memc__read_address = AW'(32'h20 + i);
      sample();
      check_value("mid_rd_acc", memc__ldst__read_ready, 1'b1);
    end
    step();
    ldst__memc__read_valid = 1'b0;
    ldst__memc__request    = 1'b0;
    reset_poweron          = 1'b1;
    sample();
    step();
    reset_poweron = 1'b0;
    sample();
    check_all_zero("midrst");
    for (int c = 0; c < 8; c++) begin
      step();
      sample();
      check_value("midrst_no_stale", {memc__ldst__read_data_valid, memc__sram__enable}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
